// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 round controller: does the initial AddRoundKey, drives one shared
// round datapath NR times with a fixed-latency capture, then hands back the ciphertext.
module aes_round_sequencer #(
    parameter int NR        = 10,
    parameter int ROUND_LAT = 2,
    parameter int W         = 128
) (
    input  logic         clock,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_pt,
    input  logic [W-1:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_ct,
    output logic         busy,
    output logic         rnd_issue,
    output logic [W-1:0] rnd_din,
    output logic [W-1:0] rnd_kin,
    output logic [3:0]   rnd_count,
    output logic         rnd_last,
    input  logic [W-1:0] rnd_dout,
    input  logic [W-1:0] rnd_kout
);

    // state | meaning
    // IDLE  | waiting for a plaintext/key pair
    // ISSUE | one-cycle strobe of the current round into the datapath
    // WAIT  | counting out datapath latency, capture on the last count
    // OUT   | ciphertext presented until the consumer takes it
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    localparam logic [3:0] NR_C  = 4'(NR);
    localparam logic [3:0] LAT_C = 4'(ROUND_LAT);

    logic [1:0]   fsm_q, fsm_d;
    logic         armed_q;
    logic [W-1:0] state_q, state_d;
    logic [W-1:0] key_q, key_d;
    logic [W-1:0] ct_q, ct_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   wait_q, wait_d;

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        ct_d    = ct_q;
        round_d = round_q;
        wait_d  = wait_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid && armed_q) begin
                    state_d = in_pt ^ in_key;
                    key_d   = in_key;
                    round_d = 4'd1;
                    fsm_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                wait_d = LAT_C;
                fsm_d  = S_WAIT;
            end
            S_WAIT: begin
                // Datapath has no valid; the count reaching 1 marks the capture cycle.
                if (wait_q == 4'd1) begin
                    state_d = rnd_dout;
                    key_d   = rnd_kout;
                    if (round_q < NR_C) begin
                        round_d = round_q + 4'd1;
                        fsm_d   = S_ISSUE;
                    end else begin
                        ct_d  = rnd_dout;
                        fsm_d = S_OUT;
                    end
                end else begin
                    wait_d = wait_q - 4'd1;
                end
            end
            S_OUT: begin
                if (out_ready) fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            armed_q <= 1'b0;
            state_q <= '0;
            key_q   <= '0;
            ct_q    <= '0;
            round_q <= '0;
            wait_q  <= '0;
        end else begin
            fsm_q   <= fsm_d;
            armed_q <= 1'b1;
            state_q <= state_d;
            key_q   <= key_d;
            ct_q    <= ct_d;
            round_q <= round_d;
            wait_q  <= wait_d;
        end
    end

    // state_q/key_q only move at capture, so round inputs stay put through WAIT.
    assign in_ready  = (fsm_q == S_IDLE) && armed_q;
    assign busy      = (fsm_q != S_IDLE);
    assign out_valid = (fsm_q == S_OUT);
    assign out_ct    = ct_q;
    assign rnd_issue = (fsm_q == S_ISSUE);
    assign rnd_din   = state_q;
    assign rnd_kin   = key_q;
    assign rnd_count = round_q;
    assign rnd_last  = (round_q == NR_C);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Bench for aes_round_sequencer: two instances (ROUND_LAT 2 and 1), each with a behavioural
// AES round datapath that emits junk outside the capture cycle; ciphertexts checked via scoreboard.
module tb_aes_round_sequencer;

    localparam int NR = 10;
    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         rst       [2];
    logic         in_valid  [2];
    logic         out_ready [2];
    logic [127:0] in_pt     [2];
    logic [127:0] in_key    [2];
    wire          in_ready  [2];
    wire          out_valid [2];
    wire  [127:0] out_ct    [2];
    wire          busy      [2];
    wire          rnd_issue [2];
    wire  [127:0] rnd_din   [2];
    wire  [127:0] rnd_kin   [2];
    wire  [3:0]   rnd_count [2];
    wire          rnd_last  [2];
    wire  [127:0] rnd_dout  [2];
    wire  [127:0] rnd_kout  [2];

    int n_tests = 0;
    int n_fail  = 0;
    logic [127:0] exp_q [$];

    function automatic logic [7:0] xt(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xt(x);
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (i != 0) inv = gmul(inv, a);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] key_step(input logic [127:0] k, input logic [3:0] rnd);
        logic [31:0] w0, w1, w2, w3, t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 1; i < 16; i++) if (i < int'(rnd)) rc = xt(rc);
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                               input logic last);
        logic [7:0]   b  [16];
        logic [7:0]   sh [16];
        logic [7:0]   m  [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] r;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int rr = 0; rr < 4; rr++) sh[rr+4*c] = b[rr + 4*((c+rr)%4)];
        for (int c = 0; c < 4; c++) begin
            a0 = sh[4*c]; a1 = sh[4*c+1]; a2 = sh[4*c+2]; a3 = sh[4*c+3];
            if (last) begin
                m[4*c] = a0; m[4*c+1] = a1; m[4*c+2] = a2; m[4*c+3] = a3;
            end else begin
                m[4*c]   = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
                m[4*c+1] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
                m[4*c+2] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
                m[4*c+3] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end
        end
        for (int i = 0; i < 16; i++) r[127-8*i -: 8] = m[i];
        return r ^ k;
    endfunction

    function automatic logic [127:0] ref_encrypt(input logic [127:0] pt, input logic [127:0] key);
        logic [127:0] s, k;
        s = pt ^ key;
        k = key;
        for (int r = 1; r <= NR; r++) begin
            k = key_step(k, 4'(r));
            s = aes_round(s, k, r == NR);
        end
        return s;
    endfunction

    function automatic logic [127:0] pop_exp();
        if (exp_q.size() == 0) return 'x;
        return exp_q.pop_front();
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 2 : 1;
        int           age = 0;
        logic [127:0] junk_d, junk_k, k_next;

        aes_round_sequencer #(.NR(NR), .ROUND_LAT(LAT), .W(128)) u_dut (
            .clock    (clock),
            .rst      (rst[g]),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .in_pt    (in_pt[g]),
            .in_key   (in_key[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_ct   (out_ct[g]),
            .busy     (busy[g]),
            .rnd_issue(rnd_issue[g]),
            .rnd_din  (rnd_din[g]),
            .rnd_kin  (rnd_kin[g]),
            .rnd_count(rnd_count[g]),
            .rnd_last (rnd_last[g]),
            .rnd_dout (rnd_dout[g]),
            .rnd_kout (rnd_kout[g])
        );

        always @(posedge clock) begin
            if (rnd_issue[g]) age <= 1;
            else if (age != 0 && age < 1000) age <= age + 1;
            junk_d <= {$urandom(), $urandom(), $urandom(), $urandom()};
            junk_k <= {$urandom(), $urandom(), $urandom(), $urandom()};
        end

        // Valid result only in the LAT-th cycle after the issue strobe.
        assign k_next      = key_step(rnd_kin[g], rnd_count[g]);
        assign rnd_dout[g] = (age == LAT) ? aes_round(rnd_din[g], k_next, rnd_last[g]) : junk_d;
        assign rnd_kout[g] = (age == LAT) ? k_next : junk_k;
    end

    // Caller is #1 after an edge with the block already offered; the next edge accepts it.
    task automatic watch(input int d, input int budget, input logic hold_valid,
                         input logic [127:0] next_pt, output int vcyc, output int n_iss,
                         output int bad_sched, output int bad_hs);
        int lat;
        lat       = (d == 0) ? 2 : 1;
        vcyc      = -1;
        n_iss     = 0;
        bad_sched = 0;
        bad_hs    = 0;
        @(posedge clock); #1;
        in_valid[d] = hold_valid;
        in_pt[d]    = next_pt;
        for (int cyc = 1; cyc <= budget; cyc++) begin
            if (out_valid[d] === 1'b1) begin
                vcyc = cyc;
                break;
            end
            if (in_ready[d] !== 1'b0 || busy[d] !== 1'b1) bad_hs++;
            if (rnd_issue[d] === 1'b1) begin
                n_iss++;
                if (cyc != 1 + (n_iss - 1) * (lat + 1) || rnd_count[d] !== 4'(n_iss) ||
                    rnd_last[d] !== (n_iss == NR)) bad_sched++;
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        n_tests++;
        if ({out_valid[0], busy[0], rnd_issue[0], rnd_last[0], in_ready[0]} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 00000",
                     {out_valid[0], busy[0], rnd_issue[0], rnd_last[0], in_ready[0]});
        end
        n_tests++;
        if (out_ct[0] !== 128'h0 || rnd_din[0] !== 128'h0 || rnd_kin[0] !== 128'h0 ||
            rnd_count[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_data: got ct %h din %h kin %h cnt %0d want all 0",
                     out_ct[0], rnd_din[0], rnd_kin[0], rnd_count[0]);
        end
        @(negedge clock);
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        #1;
        n_tests++;
        if (in_ready[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b want 0", in_ready[0]);
        end
        @(posedge clock); #1;
        n_tests++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_edge: got ready %b busy %b want 1 0", in_ready[0], busy[0]);
        end
    endtask

    task automatic test_fips(input int d);
        int lat, vcyc, n_iss, bs, bh;
        logic [127:0] exp;
        lat          = (d == 0) ? 2 : 1;
        out_ready[d] = 1'b1;
        in_valid[d]  = 1'b1;
        in_pt[d]     = FIPS_PT;
        in_key[d]    = FIPS_KEY;
        exp_q.push_back(ref_encrypt(FIPS_PT, FIPS_KEY));
        watch(d, 100, 1'b0, FIPS_PT, vcyc, n_iss, bs, bh);
        n_tests++;
        if (vcyc != NR * (lat + 1) + 1) begin
            n_fail++;
            $display("FAIL fips_latency[%0d]: got cycle %0d want %0d", d, vcyc, NR * (lat + 1) + 1);
        end
        n_tests++;
        if (n_iss != NR || bs != 0) begin
            n_fail++;
            $display("FAIL fips_schedule[%0d]: got %0d issues %0d bad want %0d issues 0 bad",
                     d, n_iss, bs, NR);
        end
        n_tests++;
        if (bh != 0) begin
            n_fail++;
            $display("FAIL fips_busy[%0d]: got %0d bad cycles want 0", d, bh);
        end
        n_tests++;
        if (out_ct[d] !== FIPS_CT) begin
            n_fail++;
            $display("FAIL fips_ct[%0d]: got %h want %h", d, out_ct[d], FIPS_CT);
        end
        exp = pop_exp();
        n_tests++;
        if (out_ct[d] !== exp) begin
            n_fail++;
            $display("FAIL fips_scoreboard[%0d]: got %h want %h", d, out_ct[d], exp);
        end
        @(posedge clock); #1;
        n_tests++;
        if (out_valid[d] !== 1'b0 || in_ready[d] !== 1'b1 || busy[d] !== 1'b0) begin
            n_fail++;
            $display("FAIL fips_release[%0d]: got valid %b ready %b busy %b want 0 1 0",
                     d, out_valid[d], in_ready[d], busy[d]);
        end
        out_ready[d] = 1'b0;
    endtask

    task automatic test_stall();
        int vcyc, n_iss, bs, bh, bad;
        logic [127:0] exp;
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_pt[0]     = FIPS_PT;
        in_key[0]    = FIPS_KEY;
        exp_q.push_back(ref_encrypt(FIPS_PT, FIPS_KEY));
        watch(0, 100, 1'b0, FIPS_PT, vcyc, n_iss, bs, bh);
        n_tests++;
        if (vcyc != 31) begin
            n_fail++;
            $display("FAIL stall_latency: got cycle %0d want 31", vcyc);
        end
        exp = pop_exp();
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid[0] !== 1'b1 || out_ct[0] !== exp || in_ready[0] !== 1'b0 ||
                busy[0] !== 1'b1) bad++;
            if (i == 5) out_ready[0] = 1'b1;
            @(posedge clock); #1;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stall_hold: got %0d bad cycles of 6 want 0 (ct %h want %h)",
                     bad, out_ct[0], exp);
        end
        n_tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got valid %b ready %b want 0 1", out_valid[0], in_ready[0]);
        end
        out_ready[0] = 1'b0;
    endtask

    task automatic test_back_to_back();
        int vcyc, n_iss, bs, bh;
        logic [127:0] pa, pb, key, exp;
        pa  = {$urandom(), $urandom(), $urandom(), $urandom()};
        pb  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_pt[0]     = pa;
        in_key[0]    = key;
        exp_q.push_back(ref_encrypt(pa, key));
        watch(0, 100, 1'b1, pb, vcyc, n_iss, bs, bh);
        n_tests++;
        if (vcyc != 31 || bh != 0) begin
            n_fail++;
            $display("FAIL b2b_first: got cycle %0d busy-bad %0d want 31 0", vcyc, bh);
        end
        exp = pop_exp();
        n_tests++;
        if (out_ct[0] !== exp) begin
            n_fail++;
            $display("FAIL b2b_ct_a: got %h want %h", out_ct[0], exp);
        end
        @(posedge clock); #1;
        n_tests++;
        if (in_ready[0] !== 1'b1 || busy[0] !== 1'b0 || out_valid[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got ready %b busy %b valid %b want 1 0 0",
                     in_ready[0], busy[0], out_valid[0]);
        end
        exp_q.push_back(ref_encrypt(pb, key));
        watch(0, 100, 1'b0, pb, vcyc, n_iss, bs, bh);
        n_tests++;
        if (vcyc != 31 || bs != 0) begin
            n_fail++;
            $display("FAIL b2b_second: got cycle %0d sched-bad %0d want 31 0", vcyc, bs);
        end
        exp = pop_exp();
        n_tests++;
        if (out_ct[0] !== exp) begin
            n_fail++;
            $display("FAIL b2b_ct_b: got %h want %h", out_ct[0], exp);
        end
        @(posedge clock); #1;
        out_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   vcyc, n_iss, bs, bh, seen;
        logic found;
        logic [127:0] pt, key, exp;
        out_ready[0] = 1'b1;
        in_valid[0]  = 1'b1;
        in_pt[0]     = FIPS_PT;
        in_key[0]    = FIPS_KEY;
        exp_q.push_back(ref_encrypt(FIPS_PT, FIPS_KEY));
        @(posedge clock); #1;
        in_valid[0] = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (rnd_issue[0] === 1'b1 && rnd_count[0] === 4'd5) found = 1'b1;
            else begin
                @(posedge clock); #1;
            end
        end
        n_tests++;
        if (!found) begin
            n_fail++;
            $display("FAIL mid_round5: got no round-5 issue want one");
        end
        @(posedge clock); #2;
        rst[0] = 1'b1;
        #1;
        exp_q.delete();
        n_tests++;
        if ({out_valid[0], busy[0], rnd_issue[0], rnd_last[0], in_ready[0]} !== 5'b0 ||
            rnd_count[0] !== 4'h0) begin
            n_fail++;
            $display("FAIL mid_flags: got %b cnt %0d want 00000 cnt 0",
                     {out_valid[0], busy[0], rnd_issue[0], rnd_last[0], in_ready[0]}, rnd_count[0]);
        end
        n_tests++;
        if (out_ct[0] !== 128'h0 || rnd_din[0] !== 128'h0 || rnd_kin[0] !== 128'h0) begin
            n_fail++;
            $display("FAIL mid_data: got ct %h din %h kin %h want all 0",
                     out_ct[0], rnd_din[0], rnd_kin[0]);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        rst[0] = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (out_valid[0] !== 1'b0 || busy[0] !== 1'b0) seen++;
        end
        n_tests++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL mid_abandon: got %0d active cycles want 0", seen);
        end
        pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid[0] = 1'b1;
        in_pt[0]    = pt;
        in_key[0]   = key;
        exp_q.push_back(ref_encrypt(pt, key));
        watch(0, 100, 1'b0, pt, vcyc, n_iss, bs, bh);
        exp = pop_exp();
        n_tests++;
        if (vcyc != 31 || out_ct[0] !== exp) begin
            n_fail++;
            $display("FAIL mid_fresh: got cycle %0d ct %h want 31 %h", vcyc, out_ct[0], exp);
        end
        @(posedge clock); #1;
        out_ready[0] = 1'b0;
    endtask

    task automatic test_random(input int d, input int n);
        int lat, vcyc, n_iss, bs, bh;
        logic [127:0] pt, key, exp;
        lat          = (d == 0) ? 2 : 1;
        out_ready[d] = 1'b1;
        for (int i = 0; i < n; i++) begin
            pt  = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid[d] = 1'b1;
            in_pt[d]    = pt;
            in_key[d]   = key;
            exp_q.push_back(ref_encrypt(pt, key));
            watch(d, 100, 1'b0, pt, vcyc, n_iss, bs, bh);
            exp = pop_exp();
            n_tests++;
            if (vcyc != NR * (lat + 1) + 1 || bs != 0 || out_ct[d] !== exp) begin
                n_fail++;
                $display("FAIL random_ct[%0d.%0d]: got cycle %0d sched-bad %0d ct %h want %0d 0 %h",
                         d, i, vcyc, bs, out_ct[d], NR * (lat + 1) + 1, exp);
            end
            @(posedge clock); #1;
        end
        out_ready[d] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rst[i]       = 1'b1;
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b0;
            in_pt[i]     = '0;
            in_key[i]    = '0;
        end
        test_reset();
        test_fips(0);
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_random(0, 2);
        test_fips(1);
        test_random(1, 2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion want finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
